// File: rtl/line_buffer_ctrl_if.sv
// Capture-side / FIFO-side bundle for the line buffer controller.
// master drives pixel and FIFO status; slave is the controller.
interface line_buffer_ctrl_if;
  logic        iSOF;
  logic        iDVAL;
  logic        iFULL;
  logic        iEMPTY;
  logic        oWREN;
  logic        oRDEN;
  logic        oTAP_VALID;
  logic        oOUT_VALID;
  logic [10:0] oX_Cont;
  logic [10:0] oY_Cont;
  logic        oBUSY;
  logic [2:0]  oERR;

  modport master (
    output iSOF, iDVAL, iFULL, iEMPTY,
    input  oWREN, oRDEN, oTAP_VALID, oOUT_VALID,
    input  oX_Cont, oY_Cont, oBUSY, oERR
  );

  modport slave (
    input  iSOF, iDVAL, iFULL, iEMPTY,
    output oWREN, oRDEN, oTAP_VALID, oOUT_VALID,
    output oX_Cont, oY_Cont, oBUSY, oERR
  );
endinterface

// File: rtl/line_buffer_ctrl.sv
// Single-line FIFO sequencer for the 2x2 Bayer-to-grey datapath:
// primes one line, streams lockstep read+write, drains at end of frame.
module line_buffer_ctrl #(
  parameter int LINE_WIDTH  = 1280,
  parameter int FRAME_LINES = 960
) (
  input logic              iCLK,
  input logic              iRST,
  line_buffer_ctrl_if.slave bus
);

  localparam logic [10:0] LW_M1 = 11'(LINE_WIDTH - 1);
  localparam logic [10:0] FL_M1 = 11'(FRAME_LINES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRIME,
    S_STREAM,
    S_DRAIN
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [10:0] r_col;
  logic [10:0] r_row;
  logic [10:0] r_drain;
  logic [10:0] w_col_nxt;
  logic [10:0] w_row_nxt;
  logic [10:0] w_drain_nxt;
  logic        w_wren;
  logic        w_rden;
  logic        w_tap;
  logic        w_clr_err;
  logic        w_col_end;
  logic        w_row_end;
  logic        w_blk;
  logic [2:0]  w_err_set;

  logic        r_out_valid;
  logic [10:0] r_x;
  logic [10:0] r_y;
  logic [2:0]  r_err;

  assign w_col_end = (r_col == LW_M1);
  assign w_row_end = (r_row == FL_M1);

  always_comb begin
    w_state_nxt = r_state;
    w_col_nxt   = r_col;
    w_row_nxt   = r_row;
    w_drain_nxt = r_drain;
    w_wren      = 1'b0;
    w_rden      = 1'b0;
    w_tap       = 1'b0;
    w_clr_err   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (bus.iSOF && bus.iDVAL) begin
          w_wren      = 1'b1;
          w_clr_err   = 1'b1;
          w_col_nxt   = 11'd1;
          w_row_nxt   = 11'd0;
          w_state_nxt = S_PRIME;
        end
      end
      S_PRIME: begin
        w_wren = bus.iDVAL;
        if (bus.iDVAL) begin
          if (w_col_end) begin
            w_col_nxt   = 11'd0;
            w_row_nxt   = 11'd1;
            w_state_nxt = S_STREAM;
          end else begin
            w_col_nxt = r_col + 11'd1;
          end
        end
      end
      S_STREAM: begin
        w_wren = bus.iDVAL;
        w_rden = bus.iDVAL;
        w_tap  = bus.iDVAL;
        if (bus.iDVAL) begin
          if (w_col_end) begin
            w_col_nxt = 11'd0;
            if (w_row_end) begin
              w_drain_nxt = 11'd0;
              w_state_nxt = S_DRAIN;
            end else begin
              w_row_nxt = r_row + 11'd1;
            end
          end else begin
            w_col_nxt = r_col + 11'd1;
          end
        end
      end
      S_DRAIN: begin
        // Pop by count only; an empty FIFO is flagged, not waited on.
        w_rden = 1'b1;
        if (r_drain == LW_M1) begin
          w_drain_nxt = 11'd0;
          w_col_nxt   = 11'd0;
          w_row_nxt   = 11'd0;
          w_state_nxt = S_IDLE;
        end else begin
          w_drain_nxt = r_drain + 11'd1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign w_blk = (r_state == S_STREAM) && bus.iDVAL &&
                 r_row[0] && r_col[0];

  assign w_err_set = {
    bus.iSOF && (r_state != S_IDLE),
    w_rden && bus.iEMPTY,
    w_wren && bus.iFULL && !w_rden
  };

  always_ff @(posedge iCLK) begin
    if (!iRST) begin
      r_state     <= S_IDLE;
      r_col       <= 11'd0;
      r_row       <= 11'd0;
      r_drain     <= 11'd0;
      r_out_valid <= 1'b0;
      r_x         <= 11'd0;
      r_y         <= 11'd0;
      r_err       <= 3'b000;
    end else begin
      r_state     <= w_state_nxt;
      r_col       <= w_col_nxt;
      r_row       <= w_row_nxt;
      r_drain     <= w_drain_nxt;
      r_out_valid <= w_blk;
      if (w_blk) begin
        r_x <= {1'b0, r_col[10:1]};
        r_y <= {1'b0, r_row[10:1]};
      end
      if (w_clr_err) begin
        r_err <= 3'b000;
      end else begin
        r_err <= r_err | w_err_set;
      end
    end
  end

  assign bus.oWREN      = w_wren;
  assign bus.oRDEN      = w_rden;
  assign bus.oTAP_VALID = w_tap;
  assign bus.oOUT_VALID = r_out_valid;
  assign bus.oX_Cont    = r_x;
  assign bus.oY_Cont    = r_y;
  assign bus.oBUSY      = (r_state != S_IDLE);
  assign bus.oERR       = r_err;

endmodule

// File: tb/tb_line_buffer_ctrl.sv
// Bench for line_buffer_ctrl: 8x4 frames against a queue-based
// show-ahead FIFO and a pixel-index reference model.
module tb_line_buffer_ctrl;

  localparam int LW = 8;
  localparam int FL = 4;
  localparam int NPIX = LW * FL;
  localparam int NOUT = (LW / 2) * (FL / 2);

  logic iCLK;
  logic iRST;
  logic r_force_empty;
  logic [11:0] r_data;
  logic [11:0] q[$];
  int q_cnt;
  int n_checks;
  int n_errs;

  line_buffer_ctrl_if bus();

  line_buffer_ctrl #(
    .LINE_WIDTH (LW),
    .FRAME_LINES(FL)
  ) dut (
    .iCLK(iCLK),
    .iRST(iRST),
    .bus (bus)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  assign bus.iEMPTY = (q_cnt == 0) || r_force_empty;
  assign bus.iFULL  = (q_cnt >= LW);

  always @(posedge iCLK) begin
    if (!iRST) begin
      q.delete();
    end else begin
      if (bus.oRDEN && q.size() > 0) void'(q.pop_front());
      if (bus.oWREN) q.push_back(r_data);
    end
    q_cnt <= q.size();
  end

  task automatic do_frame(input int pct, input int sof_at,
                          input int empty_at,
                          input logic [2:0] exp_err,
                          input string tag);
    int pulses = 0;
    int drained = 0;
    int sz;
    int col;
    int row;
    bit done = 0;
    bit exp_ov;
    logic [11:0] head;
    for (int p = 0; p < NPIX; p++) begin
      if (p > 0) begin
        while ($urandom_range(99) < pct) begin
          bus.iSOF = 1'b0;
          bus.iDVAL = 1'b0;
          sz = q.size();
          @(negedge iCLK);
          n_checks++;
          if ({bus.oWREN, bus.oRDEN, bus.oTAP_VALID} !== 3'b000) begin
            n_errs++;
            $display("FAIL %s gap_strobes p=%0d got %b exp 000", tag, p,
                     {bus.oWREN, bus.oRDEN, bus.oTAP_VALID});
          end
          @(posedge iCLK) #1;
          n_checks++;
          if (q.size() != sz || bus.oOUT_VALID !== 1'b0) begin
            n_errs++;
            $display("FAIL %s gap_hold p=%0d size %0d exp %0d ov %b exp 0",
                     tag, p, q.size(), sz, bus.oOUT_VALID);
          end
        end
      end
      col = p % LW;
      row = p / LW;
      bus.iSOF = (p == 0) || (p == sof_at);
      bus.iDVAL = 1'b1;
      r_data = 12'(p);
      r_force_empty = (p == empty_at);
      @(negedge iCLK);
      n_checks++;
      if (bus.oWREN !== 1'b1 || bus.oRDEN !== (p >= LW) ||
          bus.oTAP_VALID !== (p >= LW)) begin
        n_errs++;
        $display("FAIL %s strobes p=%0d got w%b r%b t%b exp w1 r%b t%b",
                 tag, p, bus.oWREN, bus.oRDEN, bus.oTAP_VALID,
                 p >= LW, p >= LW);
      end
      if (p >= LW && p != empty_at) begin
        head = (q.size() > 0) ? q[0] : 12'hFFF;
        n_checks++;
        if (head !== 12'(p - LW)) begin
          n_errs++;
          $display("FAIL %s tap_head p=%0d got %0d exp %0d",
                   tag, p, head, p - LW);
        end
      end else if (p < LW) begin
        n_checks++;
        if (q.size() != p) begin
          n_errs++;
          $display("FAIL %s prime_fill p=%0d got %0d exp %0d",
                   tag, p, q.size(), p);
        end
      end
      @(posedge iCLK) #1;
      r_force_empty = 1'b0;
      exp_ov = (row % 2 == 1) && (col % 2 == 1);
      n_checks++;
      if (bus.oOUT_VALID !== exp_ov) begin
        n_errs++;
        $display("FAIL %s out_valid p=%0d got %b exp %b",
                 tag, p, bus.oOUT_VALID, exp_ov);
      end
      if (exp_ov) begin
        pulses++;
        n_checks++;
        if (bus.oX_Cont !== 11'(col / 2) || bus.oY_Cont !== 11'(row / 2)) begin
          n_errs++;
          $display("FAIL %s coord p=%0d got (%0d,%0d) exp (%0d,%0d)", tag, p,
                   bus.oX_Cont, bus.oY_Cont, col / 2, row / 2);
        end
      end
    end
    bus.iSOF = 1'b0;
    for (int i = 0; i < 4 * LW && !done; i++) begin
      bus.iDVAL = 1'($urandom_range(1));
      @(negedge iCLK);
      if (!bus.oBUSY) begin
        done = 1;
      end else begin
        n_checks++;
        if (bus.oWREN !== 1'b0 || bus.oTAP_VALID !== 1'b0) begin
          n_errs++;
          $display("FAIL %s drain_wr got w%b t%b exp w0 t0", tag,
                   bus.oWREN, bus.oTAP_VALID);
        end
        if (bus.oRDEN) drained++;
        @(posedge iCLK) #1;
        n_checks++;
        if (bus.oOUT_VALID !== 1'b0) begin
          n_errs++;
          $display("FAIL %s drain_ov got %b exp 0", tag, bus.oOUT_VALID);
        end
      end
    end
    bus.iDVAL = 1'b0;
    n_checks++;
    if (!done || drained != LW) begin
      n_errs++;
      $display("FAIL %s drain done=%0d pops %0d exp 1 %0d",
               tag, done, drained, LW);
    end
    n_checks++;
    if (q.size() != 0) begin
      n_errs++;
      $display("FAIL %s fifo_empty got %0d exp 0", tag, q.size());
    end
    n_checks++;
    if (bus.oERR !== exp_err) begin
      n_errs++;
      $display("FAIL %s err got %b exp %b", tag, bus.oERR, exp_err);
    end
    n_checks++;
    if (pulses != NOUT) begin
      n_errs++;
      $display("FAIL %s pulses got %0d exp %0d", tag, pulses, NOUT);
    end
    @(posedge iCLK) #1;
  endtask

  task automatic test_reset();
    iRST = 1'b0;
    repeat (2) @(posedge iCLK);
    #1;
    n_checks++;
    if ({bus.oBUSY, bus.oOUT_VALID, bus.oERR} !== 5'b0 ||
        bus.oX_Cont !== 11'd0 || bus.oY_Cont !== 11'd0 ||
        {bus.oWREN, bus.oRDEN, bus.oTAP_VALID} !== 3'b000) begin
      n_errs++;
      $display("FAIL reset busy %b ov %b err %b x %0d y %0d exp zeros",
               bus.oBUSY, bus.oOUT_VALID, bus.oERR, bus.oX_Cont, bus.oY_Cont);
    end
    iRST = 1'b1;
    bus.iDVAL = 1'b1;
    @(negedge iCLK);
    n_checks++;
    if (bus.oWREN !== 1'b0) begin
      n_errs++;
      $display("FAIL idle_dval wren got %b exp 0", bus.oWREN);
    end
    @(posedge iCLK) #1;
    bus.iDVAL = 1'b0;
    n_checks++;
    if (bus.oBUSY !== 1'b0) begin
      n_errs++;
      $display("FAIL idle_dval busy got %b exp 0", bus.oBUSY);
    end
  endtask

  task automatic test_stream();
    do_frame(0, -1, -1, 3'b000, "stream");
  endtask

  task automatic test_gaps();
    do_frame(35, -1, -1, 3'b000, "gaps");
  endtask

  task automatic test_back_to_back();
    do_frame(0, -1, -1, 3'b000, "b2b");
  endtask

  task automatic test_errors();
    do_frame(0, 12, -1, 3'b100, "err_sof");
    do_frame(10, -1, 20, 3'b010, "err_empty");
    do_frame(0, -1, -1, 3'b000, "err_clear");
  endtask

  task automatic test_reset_mid();
    for (int p = 0; p <= 20; p++) begin
      bus.iSOF = (p == 0);
      bus.iDVAL = 1'b1;
      r_data = 12'(p);
      if (p == 20) iRST = 1'b0;
      @(posedge iCLK) #1;
    end
    iRST = 1'b1;
    bus.iSOF = 1'b0;
    bus.iDVAL = 1'b0;
    n_checks++;
    if ({bus.oBUSY, bus.oOUT_VALID, bus.oERR} !== 5'b0 ||
        bus.oX_Cont !== 11'd0 || bus.oY_Cont !== 11'd0 ||
        q.size() != 0) begin
      n_errs++;
      $display("FAIL mid_reset busy %b ov %b err %b x %0d y %0d q %0d exp 0",
               bus.oBUSY, bus.oOUT_VALID, bus.oERR, bus.oX_Cont,
               bus.oY_Cont, q.size());
    end
    bus.iDVAL = 1'b1;
    @(negedge iCLK);
    n_checks++;
    if (bus.oWREN !== 1'b0 || bus.oRDEN !== 1'b0) begin
      n_errs++;
      $display("FAIL mid_reset_idle got w%b r%b exp 00",
               bus.oWREN, bus.oRDEN);
    end
    @(posedge iCLK) #1;
    bus.iDVAL = 1'b0;
    do_frame(20, -1, -1, 3'b000, "after_reset");
  endtask

  initial begin
    n_checks = 0;
    n_errs = 0;
    iRST = 1'b0;
    r_force_empty = 1'b0;
    r_data = 12'd0;
    q_cnt = 0;
    bus.iSOF = 1'b0;
    bus.iDVAL = 1'b0;
    @(posedge iCLK) #1;
    test_reset();
    test_stream();
    test_gaps();
    test_back_to_back();
    test_errors();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule

// File: doc/line_buffer_ctrl.md
Name: line_buffer_ctrl

Overview:
- Sequences the 12-bit single-line FIFO that feeds the 2x2 Bayer-to-grey datapath.
- Counts incoming raw pixels and primes the FIFO with the first line of each frame.
- Then issues lockstep read+write strobes, so the FIFO head is always the pixel directly above the current one.
- Flags the cycles where a complete 2x2 block is available, and drains the FIFO at end of frame. Sits between the CCD capture stage and the greyscale datapath.

Parameters:
- LINE_WIDTH, 1280, pixels per line; this is also the FIFO depth; range 2..2047.
- FRAME_LINES, 960, lines per frame; range 2..2047.

Ports:
- iCLK, input, 1, clock; all logic rising-edge.
- iRST, input, 1, synchronous active-low reset.
- iSOF, input, 1, start-of-frame; qualifies the pixel presented with iDVAL in the same cycle.
- iDVAL, input, 1, raw pixel valid.
- iFULL, input, 1, FIFO full.
- iEMPTY, input, 1, FIFO empty.
- oWREN, output, 1, FIFO write strobe; combinational.
- oRDEN, output, 1, FIFO read/pop strobe; combinational.
- oTAP_VALID, output, 1, FIFO head and the current pixel are vertically aligned this cycle; combinational.
- oOUT_VALID, output, 1, one grey pixel may be produced; registered.
- oX_Cont, output, 11, grey-pixel column = col>>1; registered.
- oY_Cont, output, 11, grey-pixel row = row>>1; registered.
- oBUSY, output, 1, state != IDLE.
- oERR, output, 3, sticky flags: bit0 overflow, bit1 underflow, bit2 iSOF while busy.

Behaviour:
- Reset (iRST=0 at a clock edge):
  - state=IDLE; col=0, row=0, drain_cnt=0.
  - oOUT_VALID=0, oX_Cont=0, oY_Cont=0, oERR=0.
  - The FIFO shares iRST, so it is empty after any reset, including mid-frame.
- FIFO model: show-ahead. The head word is valid while !iEMPTY; oRDEN pops it at the clock edge. Read and write in the same cycle are legal.
- States:
  - IDLE:
    - oWREN=oRDEN=0.
    - iSOF&iDVAL -> PRIME. That pixel is written (oWREN=1), col=1, row=0, oERR cleared.
    - iDVAL without iSOF is ignored.
  - PRIME:
    - oWREN=iDVAL, oRDEN=0.
    - When the pixel at col=LINE_WIDTH-1 is written: col->0, row->1, state -> STREAM.
  - STREAM:
    - oWREN=oRDEN=oTAP_VALID=iDVAL. FIFO occupancy stays at LINE_WIDTH.
    - col increments per iDVAL and wraps LINE_WIDTH-1 -> 0, incrementing row.
    - When the pixel at col=LINE_WIDTH-1, row=FRAME_LINES-1 is accepted: state -> DRAIN, drain_cnt=0.
  - DRAIN:
    - oWREN=0, oRDEN=1 every cycle, oTAP_VALID=0.
    - drain_cnt increments each cycle; after LINE_WIDTH pops -> IDLE, col=row=0.
    - iDVAL in DRAIN: the pixel is dropped, no error.
- Gaps: iDVAL=0 in PRIME/STREAM holds all counters and strobes low. No timeout.
- Output stage:
  - Next cycle, oOUT_VALID = (previous cycle in STREAM & iDVAL & row[0]=1 & col[0]=1).
  - oX_Cont/oY_Cont load (col>>1, row>>1) of that pixel and update only when oOUT_VALID is set. Latency is 1 cycle.
  - Exactly (LINE_WIDTH/2)*(FRAME_LINES/2) pulses per frame for even parameters.
- Errors (sticky until reset or the accepted iSOF in IDLE):
  - bit0 set when oWREN & iFULL & !oRDEN.
  - bit1 set when oRDEN & iEMPTY; the controller still completes DRAIN by count.
  - bit2 set when iSOF=1 in any state but IDLE. iSOF is otherwise ignored; the frame continues.
- Simultaneous reset and any other event: reset wins.
- Arithmetic: col and row are 11-bit unsigned and never exceed LINE_WIDTH-1 and FRAME_LINES-1. drain_cnt is 11-bit.

Test Plan (LINE_WIDTH=8, FRAME_LINES=4, behavioural show-ahead FIFO model of depth 8):
1. Prime: iSOF&iDVAL, then 7 more iDVAL -> oWREN high for 8 cycles, oRDEN=0, state STREAM. FIFO holds 8 words, oTAP_VALID=0 throughout.
2. Stream alignment: feed pixel values 0..31 back-to-back -> on pixel k≥8, the popped head equals k-8. oOUT_VALID pulses at row1 cols 1,3,5,7 with (oX,oY)=(0,0),(1,0),(2,0),(3,0), each one cycle after the pixel; 8 pulses total.
3. Gaps: insert random iDVAL=0 bubbles -> counters and FIFO contents are unchanged during bubbles; same 8 outputs and coordinates as in scenario 2.
4. End of frame: after pixel 31 -> DRAIN with oRDEN=1 for exactly 8 cycles, iEMPTY at the end, oBUSY falls, oERR=000. A second iSOF starts a clean frame.
5. Errors: iSOF at pixel 12 -> oERR=100 and the frame completes normally. Force iEMPTY=1 during STREAM -> bit1 set. Next accepted iSOF clears oERR.
6. Reset mid-frame: iRST=0 for one cycle at pixel 20 -> next cycle state IDLE, all outputs 0, FIFO empty. iDVAL without iSOF is ignored; a new iSOF primes correctly.
